ram_arbiter: RTL

Two-requester access controller for the 4K x 32 single-port RAM with a shared bidirectional data bus. It arbitrates between an instruction-fetch port (read-only) and a load/store port (read/write). It sequences the RAM address, R_W strobe and tri-state data bus, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU fetch/memory stages and the RAM instance.

---
 rtl/ram_arbiter_pkg.sv | 25 ++
 rtl/ram_arbiter_if.sv | 38 +++
 rtl/ram_arbiter_rr_arb2.sv | 29 ++
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Purpose  : Shared types and constants for the ram_arbiter slice:
//            FSM state encoding, requester port IDs, default bus widths.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

   localparam int AW_DEF = 12;
   localparam int DW_DEF = 32;

   // Requester IDs; also the bit positions in the arbiter request vector.
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Purpose  : Requester handshakes plus RAM address/strobe of the arbiter.
//            slave  : the arbiter side (takes requests, drives RAM control)
//            master : the CPU/test side (issues requests, observes RAM control)
//            The bidirectional RAM data bus is a plain port on the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          ls_req;
   logic          ls_we;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic          ls_ack;
   logic [DW-1:0] ls_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_r_w;
   logic          busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      output if_ack, if_rdata, ls_ack, ls_rdata, ram_addr, ram_r_w, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      input  if_ack, if_rdata, ls_ack, ls_rdata, ram_addr, ram_r_w, busy
   );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin selector, purely combinational.
// Ports    : req   [1:0] request vector, bit PORT_IF / bit PORT_LS
//            last        port granted most recently
//            grant       winning port index (PORT_IF when nothing requests)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   always_comb begin
      grant = PORT_IF;
      if (req[PORT_IF] && req[PORT_LS]) begin
         // Conflict: hand the slot to whoever did not get the previous one.
         grant = ~last;
      end else if (req[PORT_LS]) begin
         grant = PORT_LS;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbitrates an instruction-fetch port (read-only) and a
//            load/store port onto a single-port RAM with a shared tri-state
//            data bus. Sequences address, R_W strobe and bus drive, and
//            returns registered read data with a one-cycle ack.
// Ports    : CLK      system clock, rising edge
//            Rst      asynchronous active-high reset
//            bus      ram_arbiter_if.slave (requests, acks, rdata, RAM ctl)
//            ram_data bidirectional RAM data bus
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  wire             CLK,
   input  wire             Rst,
   ram_arbiter_if.slave    bus,
   inout  wire  [DW-1:0]   ram_data
);

   state_t        state_q,    state_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          ram_r_w_q,  ram_r_w_d;
   logic [DW-1:0] wdata_q,    wdata_d;
   logic          winner_q,   winner_d;
   logic          last_q,     last_d;
   logic          if_ack_q,   if_ack_d;
   logic          ls_ack_q,   ls_ack_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] ls_rdata_q, ls_rdata_d;
   logic          busy_q,     busy_d;
   logic          grant;

   rr_arb2 u_rr_arb2 (
      .req   ({bus.ls_req, bus.if_req}),
      .last  (last_q),
      .grant (grant)
   );

   always_comb begin
      state_d    = state_q;
      ram_addr_d = ram_addr_q;
      ram_r_w_d  = 1'b0;
      wdata_d    = wdata_q;
      winner_d   = winner_q;
      last_d     = last_q;
      if_ack_d   = 1'b0;
      ls_ack_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.if_req || bus.ls_req) begin
               ram_addr_d = (grant == PORT_LS) ? bus.ls_addr : bus.if_addr;
               ram_r_w_d  = (grant == PORT_LS) && bus.ls_we;
               wdata_d    = bus.ls_wdata;
               winner_d   = grant;
               last_d     = grant;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (ram_r_w_q) begin
               // Writes skip RD_WAIT; ack is set up here so it shows in RESP.
               state_d  = ST_RESP;
               if_ack_d = (winner_q == PORT_IF);
               ls_ack_d = (winner_q == PORT_LS);
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (winner_q == PORT_LS) begin
               ls_rdata_d = ram_data;
            end else begin
               if_rdata_d = ram_data;
            end
            if_ack_d = (winner_q == PORT_IF);
            ls_ack_d = (winner_q == PORT_LS);
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         ram_addr_q <= '0;
         ram_r_w_q  <= 1'b0;
         wdata_q    <= '0;
         winner_q   <= PORT_IF;
         last_q     <= PORT_LS;
         if_ack_q   <= 1'b0;
         ls_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ram_addr_q <= ram_addr_d;
         ram_r_w_q  <= ram_r_w_d;
         wdata_q    <= wdata_d;
         winner_q   <= winner_d;
         last_q     <= last_d;
         if_ack_q   <= if_ack_d;
         ls_ack_q   <= ls_ack_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
         busy_q     <= busy_d;
      end
   end

   // ram_r_w_q is high only in ACCESS of a write, so the same register
   // gates the strobe and the bus drive: no overlap with the RAM driving.
   assign ram_data = ram_r_w_q ? wdata_q : {DW{1'bz}};

   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_r_w  = ram_r_w_q;
   assign bus.if_ack   = if_ack_q;
   assign bus.ls_ack   = ls_ack_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.busy     = busy_q;

endmodule
`default_nettype wire
